fpga_robots_game_reset: RTL and testbench

//  Reset sequencer fed by the game clock generator: consumes the game clock and its PLL lock

---
 rtl/fpga_robots_game_reset_if.sv | 28 ++
 rtl/fpga_robots_game_reset.sv | 152 +++++++++++++++
 tb/tb_fpga_robots_game_reset.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/fpga_robots_game_reset_if.sv
// Status/control bundle between the game reset sequencer and its surroundings.
// master drives the raw async inputs; slave (the sequencer) drives the staged resets.
interface fpga_robots_game_reset_if;
  logic       locked_async;
  logic       btn_async;
  logic       rst_video;
  logic       rst_logic;
  logic       ready;
  logic [7:0] loss_count;

  modport master (
    output locked_async,
    output btn_async,
    input  rst_video,
    input  rst_logic,
    input  ready,
    input  loss_count
  );

  modport slave (
    input  locked_async,
    input  btn_async,
    output rst_video,
    output rst_logic,
    output ready,
    output loss_count
  );
endinterface

// File: rtl/fpga_robots_game_reset.sv
// Staged reset sequencer: PLL lock qualifies video release, game logic follows after a lead time.
// Debounced soft-reset button restarts game logic only; lock loss resets everything and is counted.
module fpga_robots_game_reset #(
  parameter int SYNC_STAGES     = 2,
  parameter int LOCK_CYCLES     = 65536,
  parameter int VIDEO_LEAD      = 64,
  parameter int HOLD_CYCLES     = 16,
  parameter int DEBOUNCE_CYCLES = 650000,
  parameter int CNT_W           = 20
) (
  input  logic                      clk,
  input  logic                      rst_n,
  fpga_robots_game_reset_if.slave   bus
);

  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] LEAD_LAST = CNT_W'(VIDEO_LEAD - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_WAIT,
    S_STABLE,
    S_VIDEO,
    S_RUN,
    S_SOFT
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       db_cnt_q, db_cnt_d;
  logic                   level_q, level_d;
  logic                   press_q, press_d;
  logic [7:0]             loss_q, loss_d;
  logic [SYNC_STAGES-1:0] lock_sync_q;
  logic [SYNC_STAGES-1:0] btn_sync_q;
  logic                   lock_s;
  logic                   btn_s;
  logic                   loss_inc;

  assign lock_s = lock_sync_q[SYNC_STAGES-1];
  assign btn_s  = btn_sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_WAIT;
      cnt_q       <= '0;
      db_cnt_q    <= '0;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      loss_q      <= 8'd0;
      lock_sync_q <= '0;
      btn_sync_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      db_cnt_q    <= db_cnt_d;
      level_q     <= level_d;
      press_q     <= press_d;
      loss_q      <= loss_d;
      lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], bus.locked_async};
      btn_sync_q  <= {btn_sync_q[SYNC_STAGES-2:0], bus.btn_async};
    end
  end

  // Press is registered alongside the level update, so it is a single-cycle pulse.
  always_comb begin
    db_cnt_d = db_cnt_q;
    level_d  = level_q;
    press_d  = 1'b0;
    if (btn_s == level_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      db_cnt_d = '0;
      level_d  = btn_s;
      press_d  = btn_s;
    end else begin
      db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    loss_inc = 1'b0;
    case (state_q)
      S_WAIT: begin
        if (lock_s) begin
          state_d = S_STABLE;
          cnt_d   = '0;
        end
      end
      S_STABLE: begin
        if (!lock_s) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else if (cnt_q == LOCK_LAST) begin
          state_d = S_VIDEO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_VIDEO: begin
        if (!lock_s) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else if (cnt_q == LEAD_LAST) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        // Lock loss is checked first so it wins over a coincident press.
        if (!lock_s) begin
          state_d  = S_WAIT;
          cnt_d    = '0;
          loss_inc = 1'b1;
        end else if (press_q) begin
          state_d = S_SOFT;
          cnt_d   = '0;
        end
      end
      S_SOFT: begin
        if (!lock_s) begin
          state_d  = S_WAIT;
          cnt_d    = '0;
          loss_inc = 1'b1;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
    endcase
  end

  assign loss_d = (loss_inc && (loss_q != 8'hFF)) ? loss_q + 8'd1 : loss_q;

  assign bus.rst_video  = (state_q == S_WAIT) || (state_q == S_STABLE);
  assign bus.rst_logic  = (state_q != S_RUN);
  assign bus.ready      = (state_q == S_RUN);
  assign bus.loss_count = loss_q;

endmodule

// File: tb/tb_fpga_robots_game_reset.sv
// Directed bench for the game reset sequencer with short timing parameters.
// Inputs change 1ns after a rising edge; outputs are sampled at the same point.
module tb_fpga_robots_game_reset;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  fpga_robots_game_reset_if bus ();

  fpga_robots_game_reset #(
    .SYNC_STAGES     (2),
    .LOCK_CYCLES     (8),
    .VIDEO_LEAD      (4),
    .HOLD_CYCLES     (3),
    .DEBOUNCE_CYCLES (5),
    .CNT_W           (20)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic wait_ready(input string tag);
    int t;
    t = 0;
    while (!bus.ready && t < 60) begin
      tick();
      t++;
    end
    check(tag, 32'(bus.ready), 32'd1);
  endtask

  initial begin
    int logic_hi;
    int pulses;
    int video_hi;
    int ready_bad;
    logic prev_logic;

    n_checks = 0;
    n_pass   = 0;
    rst_n            = 1'b0;
    bus.locked_async = 1'b1;
    bus.btn_async    = 1'b0;
    tick();
    tick();
    check("reset_video", 32'(bus.rst_video), 32'd1);
    check("reset_logic", 32'(bus.rst_logic), 32'd1);
    check("reset_ready", 32'(bus.ready), 32'd0);
    check("reset_loss", 32'(bus.loss_count), 32'd0);

    // 1: release with lock already high
    rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 10) check("t1_video_e10", 32'(bus.rst_video), 32'd1);
      if (k == 11) check("t1_video_e11", 32'(bus.rst_video), 32'd0);
      if (k == 11) check("t1_logic_e11", 32'(bus.rst_logic), 32'd1);
      if (k == 14) check("t1_logic_e14", 32'(bus.rst_logic), 32'd1);
      if (k == 14) check("t1_ready_e14", 32'(bus.ready), 32'd0);
      if (k == 15) check("t1_logic_e15", 32'(bus.rst_logic), 32'd0);
      if (k == 15) check("t1_ready_e15", 32'(bus.ready), 32'd1);
    end
    check("t1_loss", 32'(bus.loss_count), 32'd0);

    // 2: one-cycle synced lock glitch at cnt=5 restarts the stability count
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 1; k <= 22; k++) begin
      tick();
      if (k == 6) bus.locked_async = 1'b0;
      if (k == 7) bus.locked_async = 1'b1;
      if (k == 11) check("t2_video_e11", 32'(bus.rst_video), 32'd1);
      if (k == 17) check("t2_video_e17", 32'(bus.rst_video), 32'd1);
      if (k == 18) check("t2_video_e18", 32'(bus.rst_video), 32'd0);
      if (k == 21) check("t2_ready_e21", 32'(bus.ready), 32'd0);
      if (k == 22) check("t2_ready_e22", 32'(bus.ready), 32'd1);
    end

    // 3: lock loss in S_RUN, then saturate the loss counter
    bus.locked_async = 1'b0;
    tick();
    tick();
    check("t3_ready_before", 32'(bus.ready), 32'd1);
    tick();
    check("t3_video", 32'(bus.rst_video), 32'd1);
    check("t3_logic", 32'(bus.rst_logic), 32'd1);
    check("t3_ready", 32'(bus.ready), 32'd0);
    check("t3_loss1", 32'(bus.loss_count), 32'd1);
    for (int i = 2; i <= 300; i++) begin
      bus.locked_async = 1'b1;
      wait_ready("t3_relock");
      bus.locked_async = 1'b0;
      tick();
      tick();
      tick();
      if (i == 254) check("t3_loss254", 32'(bus.loss_count), 32'd254);
      if (i == 255) check("t3_loss255", 32'(bus.loss_count), 32'd255);
    end
    check("t3_loss_sat", 32'(bus.loss_count), 32'd255);

    // Clear the counter and come back up
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rst_clears_loss", 32'(bus.loss_count), 32'd0);
    bus.locked_async = 1'b1;
    wait_ready("t4_ready_initial");

    // 4: bouncy press yields exactly one 3-cycle logic reset
    logic_hi   = 0;
    pulses     = 0;
    video_hi   = 0;
    ready_bad  = 0;
    prev_logic = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (k < 2)      bus.btn_async = 1'b1;
      else if (k < 4) bus.btn_async = 1'b0;
      else if (k < 6) bus.btn_async = 1'b1;
      else if (k < 8) bus.btn_async = 1'b0;
      else            bus.btn_async = 1'b1;
      tick();
      if (bus.rst_logic) logic_hi++;
      if (bus.rst_logic && !prev_logic) pulses++;
      if (bus.rst_video) video_hi++;
      if (bus.ready == bus.rst_logic) ready_bad++;
      prev_logic = bus.rst_logic;
    end
    check("t4_logic_cycles", 32'(logic_hi), 32'd3);
    check("t4_pulses", 32'(pulses), 32'd1);
    check("t4_video_hi", 32'(video_hi), 32'd0);
    check("t4_ready_vs_logic", 32'(ready_bad), 32'd0);
    check("t4_ready_end", 32'(bus.ready), 32'd1);

    bus.btn_async = 1'b0;
    for (int k = 0; k < 20; k++) tick();
    check("release_no_pulse_ready", 32'(bus.ready), 32'd1);
    check("release_no_pulse_logic", 32'(bus.rst_logic), 32'd0);

    // 5: press pulse and synced lock loss hit the FSM on the same edge
    bus.btn_async = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    bus.locked_async = 1'b0;
    tick();
    tick();
    check("t5_ready_before", 32'(bus.ready), 32'd1);
    check("t5_loss_before", 32'(bus.loss_count), 32'd0);
    tick();
    check("t5_video", 32'(bus.rst_video), 32'd1);
    check("t5_logic", 32'(bus.rst_logic), 32'd1);
    check("t5_loss", 32'(bus.loss_count), 32'd1);

    // press landing in S_VIDEO is dropped
    bus.btn_async = 1'b0;
    for (int k = 0; k < 12; k++) tick();
    bus.locked_async = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      tick();
      if (k == 5) bus.btn_async = 1'b1;
      if (k == 11) check("t5v_video_e11", 32'(bus.rst_video), 32'd0);
      if (k == 14) check("t5v_ready_e14", 32'(bus.ready), 32'd0);
      if (k == 15) check("t5v_ready_e15", 32'(bus.ready), 32'd1);
      if (k == 25) check("t5v_ready_e25", 32'(bus.ready), 32'd1);
      if (k == 25) check("t5v_logic_e25", 32'(bus.rst_logic), 32'd0);
    end

    // 6: reset during S_SOFT
    bus.btn_async = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    bus.btn_async = 1'b1;
    for (int k = 0; k < 8; k++) tick();
    check("t6_soft_video", 32'(bus.rst_video), 32'd0);
    check("t6_soft_logic", 32'(bus.rst_logic), 32'd1);
    check("t6_soft_ready", 32'(bus.ready), 32'd0);
    rst_n = 1'b0;
    tick();
    check("t6_video", 32'(bus.rst_video), 32'd1);
    check("t6_logic", 32'(bus.rst_logic), 32'd1);
    check("t6_ready", 32'(bus.ready), 32'd0);
    check("t6_loss", 32'(bus.loss_count), 32'd0);
    rst_n = 1'b1;
    tick();
    check("t6_video_after", 32'(bus.rst_video), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
